// File: rtl/core_ex_ctrl.sv
// Execute-stage controller for the RV32I core.
// Holds the ID/EX register, forwards operands into the ALU, stalls on
// load-use hazards, and turns taken branch/JALR decisions into a
// one-cycle fetch redirect. Feeds the EX/MEM register toward MEM/WB.
module core_ex_ctrl #(
  parameter bit FWD_EN       = 1'b1,
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_id_valid,
  output logic        o_id_ready,
  input  logic [6:0]  i_id_opcode,
  input  logic [6:0]  i_id_funct7,
  input  logic [2:0]  i_id_funct3,
  input  logic [31:0] i_id_pc,
  input  logic [31:0] i_id_imm,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic [4:0]  i_id_rd,
  input  logic [31:0] i_id_rs1_val,
  input  logic [31:0] i_id_rs2_val,
  output logic [6:0]  o_alu_opcode,
  output logic [6:0]  o_alu_funct7,
  output logic [2:0]  o_alu_funct3,
  output logic [31:0] o_alu_num1,
  output logic [31:0] o_alu_num2,
  output logic [31:0] o_alu_pc,
  output logic [31:0] o_alu_imm,
  input  logic [31:0] i_alu_res,
  input  logic [31:0] i_alu_target,
  input  logic        i_alu_branch,
  output logic        o_ex_valid,
  input  logic        i_ex_ready,
  output logic [31:0] o_ex_res,
  output logic [31:0] o_ex_store_data,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_wen,
  output logic [6:0]  o_ex_opcode,
  output logic [2:0]  o_ex_funct3,
  input  logic        i_wb_wen,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_exc_misalign,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_redir_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_EXEC  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_BRANCH) || (op == OP_STORE);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    logic w;
    case (op)
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  state_t      state_r, state_nx_s;
  logic [6:0]  opcode_r, funct7_r;
  logic [2:0]  funct3_r;
  logic [31:0] pc_r, imm_r, rs1_val_r, rs2_val_r;
  logic [4:0]  rs1_r, rs2_r, rd_r;
  logic        ex_valid_r, ex_wen_r;
  logic [31:0] ex_res_r, ex_store_r;
  logic [4:0]  ex_rd_r;
  logic [6:0]  ex_opcode_r;
  logic [2:0]  ex_funct3_r;
  logic [31:0] stall_cnt_r, redir_cnt_r;

  logic        id_ready_s, id_fire_s, adv_s, redirect_s, misalign_s, ctrl_taken_s;
  logic        rs1_use_s, rs2_use_s, ex_m1_s, ex_m2_s, wb_m1_s, wb_m2_s;
  logic        ld_hz_s, raw_hz_s, hazard_s, ex_mem_is_load_s;
  logic [31:0] num1_s, num2_s;

  assign rs1_use_s        = uses_rs1(opcode_r) && (rs1_r != 5'd0);
  assign rs2_use_s        = uses_rs2(opcode_r) && (rs2_r != 5'd0);
  assign ex_mem_is_load_s = (ex_opcode_r == OP_LOAD);
  assign ex_m1_s = ex_valid_r && ex_wen_r && (ex_rd_r == rs1_r);
  assign ex_m2_s = ex_valid_r && ex_wen_r && (ex_rd_r == rs2_r);
  assign wb_m1_s = i_wb_wen && (i_wb_rd == rs1_r);
  assign wb_m2_s = i_wb_wen && (i_wb_rd == rs2_r);

  // Load in EX/MEM cannot be forwarded yet; without forwarding every RAW stalls.
  assign ld_hz_s  = ex_valid_r && ex_mem_is_load_s && (ex_rd_r != 5'd0) &&
                    ((rs1_use_s && (ex_rd_r == rs1_r)) || (rs2_use_s && (ex_rd_r == rs2_r)));
  assign raw_hz_s = (rs1_use_s && (ex_m1_s || wb_m1_s)) || (rs2_use_s && (ex_m2_s || wb_m2_s));
  assign hazard_s = ld_hz_s || (!FWD_EN && raw_hz_s);

  assign ctrl_taken_s = ((opcode_r == OP_BRANCH) || (opcode_r == OP_JALR)) && i_alu_branch;

  // Operand select: EX/MEM result, then writeback data, then captured register value.
  always_comb begin
    num1_s = rs1_val_r;
    num2_s = rs2_val_r;
    if (rs1_r == 5'd0) num1_s = 32'd0;
    else if (FWD_EN && ex_m1_s && !ex_mem_is_load_s) num1_s = ex_res_r;
    else if (FWD_EN && wb_m1_s) num1_s = i_wb_data;
    else num1_s = rs1_val_r;
    if (rs2_r == 5'd0) num2_s = 32'd0;
    else if (FWD_EN && ex_m2_s && !ex_mem_is_load_s) num2_s = ex_res_r;
    else if (FWD_EN && wb_m2_s) num2_s = i_wb_data;
    else num2_s = rs2_val_r;
  end

  // Next state, handshake and control-transfer decode.
  always_comb begin
    state_nx_s = state_r;
    id_ready_s = 1'b0;
    adv_s      = 1'b0;
    redirect_s = 1'b0;
    misalign_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        id_ready_s = 1'b1;
        if (i_id_valid) state_nx_s = ST_EXEC;
        else state_nx_s = ST_EMPTY;
      end
      ST_EXEC: begin
        if (hazard_s) begin
          state_nx_s = ST_STALL;
        end else if (!ex_valid_r || i_ex_ready) begin
          adv_s = 1'b1;
          if (ctrl_taken_s) begin
            // Block ID capture while the front end is flushed.
            if (MISALIGN_CHK && i_alu_target[1]) misalign_s = 1'b1;
            else redirect_s = 1'b1;
          end else begin
            id_ready_s = 1'b1;
          end
          if (id_ready_s && i_id_valid) state_nx_s = ST_EXEC;
          else state_nx_s = ST_EMPTY;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_STALL: begin
        if (hazard_s) state_nx_s = ST_STALL;
        else state_nx_s = ST_EXEC;
      end
      default: state_nx_s = ST_EMPTY;
    endcase
  end

  assign id_fire_s = i_id_valid && id_ready_s;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_EMPTY;
    else state_r <= state_nx_s;
  end

  // ID/EX register; operand values track writebacks while the instruction waits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opcode_r <= 7'd0; funct7_r <= 7'd0; funct3_r <= 3'd0;
      pc_r <= 32'd0; imm_r <= 32'd0; rs1_r <= 5'd0; rs2_r <= 5'd0; rd_r <= 5'd0;
      rs1_val_r <= 32'd0; rs2_val_r <= 32'd0;
    end else if (id_fire_s) begin
      opcode_r <= i_id_opcode; funct7_r <= i_id_funct7; funct3_r <= i_id_funct3;
      pc_r <= i_id_pc; imm_r <= i_id_imm; rs1_r <= i_id_rs1; rs2_r <= i_id_rs2; rd_r <= i_id_rd;
      rs1_val_r <= (i_wb_wen && (i_wb_rd == i_id_rs1)) ? i_wb_data : i_id_rs1_val;
      rs2_val_r <= (i_wb_wen && (i_wb_rd == i_id_rs2)) ? i_wb_data : i_id_rs2_val;
    end else begin
      if (wb_m1_s) rs1_val_r <= i_wb_data;
      else rs1_val_r <= rs1_val_r;
      if (wb_m2_s) rs2_val_r <= i_wb_data;
      else rs2_val_r <= rs2_val_r;
    end
  end

  // EX/MEM register: load on advance, drop valid once MEM/WB accepts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_valid_r <= 1'b0; ex_res_r <= 32'd0; ex_store_r <= 32'd0; ex_rd_r <= 5'd0;
      ex_wen_r <= 1'b0; ex_opcode_r <= 7'd0; ex_funct3_r <= 3'd0;
    end else if (adv_s) begin
      ex_valid_r  <= 1'b1;
      ex_res_r    <= i_alu_res;
      ex_store_r  <= num2_s;
      ex_rd_r     <= rd_r;
      ex_wen_r    <= writes_rd(opcode_r) && (rd_r != 5'd0) && !misalign_s;
      ex_opcode_r <= opcode_r;
      ex_funct3_r <= funct3_r;
    end else if (i_ex_ready) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // Performance counters, free-running with natural wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= 32'd0;
      redir_cnt_r <= 32'd0;
    end else begin
      if (state_r == ST_STALL) stall_cnt_r <= stall_cnt_r + 32'd1;
      else stall_cnt_r <= stall_cnt_r;
      if (redirect_s) redir_cnt_r <= redir_cnt_r + 32'd1;
      else redir_cnt_r <= redir_cnt_r;
    end
  end

  // LOAD/STORE reuse the ADDI datapath so the ALU yields rs1+imm.
  assign o_alu_opcode = ((opcode_r == OP_LOAD) || (opcode_r == OP_STORE)) ? OP_IMM : opcode_r;
  assign o_alu_funct3 = ((opcode_r == OP_LOAD) || (opcode_r == OP_STORE)) ? 3'b000 : funct3_r;
  assign o_alu_funct7 = funct7_r;
  assign o_alu_num1   = num1_s;
  assign o_alu_num2   = num2_s;
  assign o_alu_pc     = pc_r;
  assign o_alu_imm    = imm_r;

  assign o_id_ready      = id_ready_s;
  assign o_ex_valid      = ex_valid_r;
  assign o_ex_res        = ex_res_r;
  assign o_ex_store_data = ex_store_r;
  assign o_ex_rd         = ex_rd_r;
  assign o_ex_wen        = ex_wen_r;
  assign o_ex_opcode     = ex_opcode_r;
  assign o_ex_funct3     = ex_funct3_r;
  assign o_redirect      = redirect_s;
  assign o_redirect_pc   = redirect_s ? (i_alu_target & 32'hFFFF_FFFE) : 32'd0;
  assign o_exc_misalign  = misalign_s;
  assign o_stall_cnt     = stall_cnt_r;
  assign o_redir_cnt     = redir_cnt_r;

endmodule

// File: tb/tb_core_ex_ctrl.sv
// Bench for core_ex_ctrl: behavioural ALU, register file and MEM/WB stage
// around the DUT; expected EX/MEM outputs go through a scoreboard queue.
module tb_core_ex_ctrl;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011, OP_LUI = 7'b0110111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [31:0] LOAD_DATA = 32'h0000_0010;

  logic i_clk = 1'b0, i_rst_n = 1'b0, i_id_valid = 1'b0, i_ex_ready = 1'b1;
  logic o_id_ready, o_ex_valid, o_ex_wen, o_redirect, o_exc_misalign;
  logic [6:0] i_id_opcode = 7'd0, i_id_funct7 = 7'd0, o_alu_opcode, o_alu_funct7, o_ex_opcode;
  logic [2:0] i_id_funct3 = 3'd0, o_alu_funct3, o_ex_funct3;
  logic [31:0] i_id_pc = 32'd0, i_id_imm = 32'd0;
  logic [4:0] i_id_rs1 = 5'd0, i_id_rs2 = 5'd0, i_id_rd = 5'd0, o_ex_rd;
  wire logic [31:0] i_id_rs1_val, i_id_rs2_val;
  logic [31:0] o_alu_num1, o_alu_num2, o_alu_pc, o_alu_imm;
  logic [31:0] i_alu_res, i_alu_target;
  logic i_alu_branch;
  logic [31:0] o_ex_res, o_ex_store_data, o_redirect_pc, o_stall_cnt, o_redir_cnt;
  logic i_wb_wen = 1'b0;
  logic [4:0] i_wb_rd = 5'd0;
  logic [31:0] i_wb_data = 32'd0;

  core_ex_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_opcode(i_id_opcode), .i_id_funct7(i_id_funct7), .i_id_funct3(i_id_funct3),
    .i_id_pc(i_id_pc), .i_id_imm(i_id_imm), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rd(i_id_rd), .i_id_rs1_val(i_id_rs1_val), .i_id_rs2_val(i_id_rs2_val),
    .o_alu_opcode(o_alu_opcode), .o_alu_funct7(o_alu_funct7), .o_alu_funct3(o_alu_funct3),
    .o_alu_num1(o_alu_num1), .o_alu_num2(o_alu_num2), .o_alu_pc(o_alu_pc), .o_alu_imm(o_alu_imm),
    .i_alu_res(i_alu_res), .i_alu_target(i_alu_target), .i_alu_branch(i_alu_branch),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready), .o_ex_res(o_ex_res),
    .o_ex_store_data(o_ex_store_data), .o_ex_rd(o_ex_rd), .o_ex_wen(o_ex_wen),
    .o_ex_opcode(o_ex_opcode), .o_ex_funct3(o_ex_funct3), .i_wb_wen(i_wb_wen),
    .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_exc_misalign(o_exc_misalign),
    .o_stall_cnt(o_stall_cnt), .o_redir_cnt(o_redir_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Register file written at the end of each writeback cycle.
  logic [31:0] rf [32];
  assign i_id_rs1_val = rf[i_id_rs1];
  assign i_id_rs2_val = rf[i_id_rs2];

  // Behavioural ALU.
  always_comb begin
    i_alu_res = 32'd0; i_alu_target = 32'd0; i_alu_branch = 1'b0;
    case (o_alu_opcode)
      OP_IMM: i_alu_res = o_alu_num1 + o_alu_imm;
      OP_REG: i_alu_res = o_alu_funct7[5] ? (o_alu_num1 - o_alu_num2) : (o_alu_num1 + o_alu_num2);
      OP_LUI: i_alu_res = o_alu_imm;
      OP_BR: begin
        i_alu_target = o_alu_pc + o_alu_imm;
        i_alu_branch = (o_alu_funct3 == 3'b000) ? (o_alu_num1 == o_alu_num2) : (o_alu_num1 != o_alu_num2);
      end
      OP_JALR: begin
        i_alu_res = o_alu_pc + 32'd4; i_alu_target = o_alu_num1 + o_alu_imm; i_alu_branch = 1'b1;
      end
      default: i_alu_res = 32'd0;
    endcase
  end

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic [31:0] imm; logic [31:0] pc;
    logic [31:0] exp_res; logic exp_wen; logic chk_sd; logic [31:0] exp_sd;
  } vec_t;
  typedef struct { logic [31:0] res; logic wen; logic [4:0] rd; logic chk_sd; logic [31:0] sd; } sb_t;

  sb_t sb_q[$];
  int nvec = 0, nerr = 0;
  logic pend_wen = 1'b0; logic [4:0] pend_rd = 5'd0; logic [31:0] pend_data = 32'd0;
  int redir_pulses = 0, misal_pulses = 0;
  logic [31:0] redir_pc_seen = 32'd0;
  logic redir_rdy_seen = 1'b0, both_seen = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Output monitor on the falling edge: scoreboard pops and redirect tracking.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      pend_wen = 1'b0;
    end else begin
      if (o_redirect) begin
        redir_pulses++; redir_pc_seen = o_redirect_pc;
        if (o_id_ready) redir_rdy_seen = 1'b1;
      end
      if (o_exc_misalign) misal_pulses++;
      if (o_redirect && o_exc_misalign) both_seen = 1'b1;
      if (o_ex_valid && i_ex_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("ex_res", o_ex_res, e.res);
          chk("ex_wen", {31'd0, o_ex_wen}, {31'd0, e.wen});
          if (e.wen) chk("ex_rd", {27'd0, o_ex_rd}, {27'd0, e.rd});
          if (e.chk_sd) chk("ex_store_data", o_ex_store_data, e.sd);
        end
        pend_wen = o_ex_wen; pend_rd = o_ex_rd;
        pend_data = (o_ex_opcode == OP_LOAD) ? LOAD_DATA : o_ex_res;
      end else begin
        pend_wen = 1'b0;
      end
    end
  end

  // MEM/WB model: writeback appears the cycle after a transfer.
  initial forever begin
    @(posedge i_clk); #1;
    if (i_wb_wen && (i_wb_rd != 5'd0)) rf[i_wb_rd] = i_wb_data;
    i_wb_wen = pend_wen; i_wb_rd = pend_rd; i_wb_data = pend_data;
  end

  task automatic set_id(input vec_t v);
    sb_t e;
    i_id_valid = 1'b1; i_id_opcode = v.op; i_id_funct3 = v.f3; i_id_funct7 = v.f7;
    i_id_rd = v.rd; i_id_rs1 = v.rs1; i_id_rs2 = v.rs2; i_id_imm = v.imm; i_id_pc = v.pc;
    e.res = v.exp_res; e.wen = v.exp_wen; e.rd = v.rd; e.chk_sd = v.chk_sd; e.sd = v.exp_sd;
    sb_q.push_back(e);
  endtask

  task automatic wait_fire();
    int n = 0;
    @(negedge i_clk);
    while (!o_id_ready && n < 50) begin n++; @(negedge i_clk); end
    if (!o_id_ready) chk("id_fire_timeout", 32'd0, 32'd1);
    @(posedge i_clk); #1;
  endtask

  task automatic send(input vec_t v);
    set_id(v);
    wait_fire();
  endtask

  task automatic drain();
    int n = 0;
    i_id_valid = 1'b0;
    while (sb_q.size() != 0 && n < 50) begin n++; @(negedge i_clk); end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm, logic [31:0] pc,
                              logic [31:0] res, logic wen);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.exp_res = res; v.exp_wen = wen; v.chk_sd = 1'b0; v.exp_sd = 32'd0;
    return v;
  endfunction

  vec_t tbl[11];
  logic [31:0] c0;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    tbl[0]  = mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0, 32'd5, 1'b1);
    tbl[1]  = mk(OP_REG, 3'd0, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'h4, 32'd10, 1'b1);
    tbl[2]  = mk(OP_IMM, 3'd0, 7'd0, 5'd5, 5'd2, 5'd0, 32'd3, 32'h8, 32'd13, 1'b1);
    tbl[3]  = mk(OP_REG, 3'd0, 7'd0, 5'd6, 5'd1, 5'd2, 32'd0, 32'hC, 32'd15, 1'b1);
    tbl[4]  = mk(OP_REG, 3'd0, 7'b0100000, 5'd7, 5'd6, 5'd1, 32'd0, 32'h10, 32'd10, 1'b1);
    tbl[5]  = mk(OP_LUI, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5000, 32'h14, 32'h1234_5000, 1'b1);
    tbl[6]  = mk(OP_REG, 3'd0, 7'd0, 5'd0, 5'd8, 5'd8, 32'd0, 32'h18, 32'h2468_A000, 1'b0);
    tbl[7]  = mk(OP_REG, 3'd0, 7'd0, 5'd9, 5'd0, 5'd8, 32'd0, 32'h1C, 32'h1234_5000, 1'b1);
    tbl[8]  = mk(OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd8, 32'd8, 32'h20, 32'd13, 1'b0);
    tbl[8].chk_sd = 1'b1; tbl[8].exp_sd = 32'h1234_5000;
    tbl[9]  = mk(OP_LOAD, 3'b010, 7'd0, 5'd10, 5'd2, 5'd0, 32'd4, 32'h24, 32'd14, 1'b1);
    tbl[10] = mk(OP_REG, 3'd0, 7'd0, 5'd11, 5'd7, 5'd5, 32'd0, 32'h28, 32'd23, 1'b1);

    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_id_ready", {31'd0, o_id_ready}, 32'd1);
    chk("rst_ex_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("rst_stall_cnt", o_stall_cnt, 32'd0);
    chk("rst_redir_cnt", o_redir_cnt, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Back-to-back stream with forwarding.
    for (int i = 0; i < 11; i++) send(tbl[i]);
    drain();
    chk("no_stall_stream", o_stall_cnt, 32'd0);

    // Load-use: exactly one stall cycle.
    c0 = o_stall_cnt;
    send(mk(OP_LOAD, 3'b010, 7'd0, 5'd3, 5'd0, 5'd0, 32'h40, 32'h30, 32'h40, 1'b1));
    send(mk(OP_IMM, 3'd0, 7'd0, 5'd4, 5'd3, 5'd0, 32'd1, 32'h34, 32'h11, 1'b1));
    drain();
    chk("load_use_stalls", o_stall_cnt - c0, 32'd1);

    // Taken BEQ redirect.
    redir_pulses = 0; misal_pulses = 0; redir_rdy_seen = 1'b0; c0 = o_redir_cnt;
    send(mk(OP_BR, 3'b000, 7'd0, 5'd0, 5'd1, 5'd1, 32'h20, 32'h100, 32'd0, 1'b0));
    drain();
    chk("beq_pulses", redir_pulses, 32'd1);
    chk("beq_target", redir_pc_seen, 32'h120);
    chk("beq_ready_low", {31'd0, redir_rdy_seen}, 32'd0);
    chk("beq_redir_cnt", o_redir_cnt - c0, 32'd1);

    // Untaken BNE: no pulse.
    redir_pulses = 0;
    send(mk(OP_BR, 3'b001, 7'd0, 5'd0, 5'd1, 5'd1, 32'h40, 32'h200, 32'd0, 1'b0));
    drain();
    chk("bne_no_pulse", redir_pulses, 32'd0);

    // JALR aligned and misaligned targets.
    redir_pulses = 0; misal_pulses = 0;
    send(mk(OP_IMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'h201, 32'h3C, 32'h201, 1'b1));
    send(mk(OP_JALR, 3'd0, 7'd0, 5'd5, 5'd9, 5'd0, 32'd0, 32'h40, 32'h44, 1'b1));
    drain();
    chk("jalr_pulses", redir_pulses, 32'd1);
    chk("jalr_target", redir_pc_seen, 32'h200);
    chk("jalr_no_misalign", misal_pulses, 32'd0);
    redir_pulses = 0; c0 = o_redir_cnt;
    send(mk(OP_IMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'h202, 32'h3C, 32'h202, 1'b1));
    send(mk(OP_JALR, 3'd0, 7'd0, 5'd5, 5'd9, 5'd0, 32'd0, 32'h40, 32'h44, 1'b0));
    drain();
    chk("misalign_pulses", misal_pulses, 32'd1);
    chk("misalign_no_redirect", redir_pulses, 32'd0);
    chk("misalign_redir_cnt", o_redir_cnt - c0, 32'd0);
    chk("never_both", {31'd0, both_seen}, 32'd0);

    // Backpressure from MEM/WB.
    i_ex_ready = 1'b0;
    send(mk(OP_IMM, 3'd0, 7'd0, 5'd12, 5'd0, 5'd0, 32'd7, 32'h50, 32'd7, 1'b1));
    send(mk(OP_IMM, 3'd0, 7'd0, 5'd13, 5'd12, 5'd0, 32'd1, 32'h54, 32'd8, 1'b1));
    set_id(mk(OP_IMM, 3'd0, 7'd0, 5'd14, 5'd13, 5'd0, 32'd2, 32'h58, 32'd10, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("bp_ex_valid", {31'd0, o_ex_valid}, 32'd1);
      chk("bp_ex_res", o_ex_res, 32'd7);
      chk("bp_ex_rd", {27'd0, o_ex_rd}, 32'd12);
      chk("bp_id_ready", {31'd0, o_id_ready}, 32'd0);
    end
    @(posedge i_clk); #1;
    i_ex_ready = 1'b1;
    wait_fire();
    drain();

    // Asynchronous reset in the middle of a stall.
    i_ex_ready = 1'b0;
    send(mk(OP_LOAD, 3'b010, 7'd0, 5'd20, 5'd0, 5'd0, 32'd0, 32'h60, 32'd0, 1'b1));
    send(mk(OP_IMM, 3'd0, 7'd0, 5'd21, 5'd20, 5'd0, 32'd1, 32'h64, 32'd0, 1'b1));
    i_id_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("stall_counting", {31'd0, (o_stall_cnt > 32'd1)}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("arst_redirect", {31'd0, o_redirect}, 32'd0);
    chk("arst_stall_cnt", o_stall_cnt, 32'd0);
    chk("arst_redir_cnt", o_redir_cnt, 32'd0);
    chk("arst_id_ready", {31'd0, o_id_ready}, 32'd1);
    sb_q.delete();
    i_ex_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    send(mk(OP_IMM, 3'd0, 7'd0, 5'd22, 5'd0, 5'd0, 32'd3, 32'h70, 32'd3, 1'b1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
